// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - shared constants and stage record for the pipelined ripple-carry adder
// PIPE_RCA_SUB_EN adds the per-beat subtract flag to the stage record.
package pipe_rca_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;
    localparam int MAX_WIDTH = 64;

    // One pipeline stage: operand bits not yet added ride along skewed,
    // finished sum segments accumulate in s.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 ovf;
`ifdef PIPE_RCA_SUB_EN
        logic                 sub;
`endif
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_WIDTH-1:0] s;
    } stage_t;

endpackage

// File: rtl/pipe_rca_seg.sv
// rtl/pipe_rca_seg.sv - combinational SEG-bit ripple segment
// Also exports the carry into its MSB so the top segment can flag signed overflow.
module pipe_rca_seg
    import pipe_rca_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);

    logic [SEG:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SEG];
    assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - pipelined ripple-carry adder, SEG bits per stage, valid/ready handshake
// Define PIPE_RCA_SUB_EN to add the sub port (a - b - cin per beat).
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || WIDTH > MAX_WIDTH || SEG < 1) begin : g_bad_cfg
        $error("pipe_rca: WIDTH must be a multiple of SEG and at most MAX_WIDTH");
    end

    stage_t in_rec;
    stage_t last_q;

    always_comb begin
        in_rec              = '0;
        in_rec.valid        = in_valid;
        in_rec.a[WIDTH-1:0] = a;
        in_rec.b[WIDTH-1:0] = b;
`ifdef PIPE_RCA_SUB_EN
        in_rec.sub          = sub;
        in_rec.carry        = cin ^ sub;
`else
        in_rec.carry        = cin;
`endif
    end

    // The whole pipe advances together; bubbles move whenever the output is not stalled.
    assign in_ready = !(last_q.valid && !out_ready);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         src;
        stage_t         stg_d;
        stage_t         stg_q;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_s;
        logic           seg_co;
        logic           seg_cm;

        if (k == 0) begin : g_first
            assign src = in_rec;
        end else begin : g_next
            assign src = g_stage[k-1].stg_q;
        end

`ifdef PIPE_RCA_SUB_EN
        assign seg_b = src.b[k*SEG +: SEG] ^ {SEG{src.sub}};
`else
        assign seg_b = src.b[k*SEG +: SEG];
`endif

        pipe_rca_seg #(.SEG(SEG)) u_seg (
            .a    (src.a[k*SEG +: SEG]),
            .b    (seg_b),
            .cin  (src.carry),
            .s    (seg_s),
            .cout (seg_co),
            .cmsb (seg_cm)
        );

        always_comb begin
            stg_d                  = src;
            stg_d.s[k*SEG +: SEG]  = seg_s;
            stg_d.carry            = seg_co;
            stg_d.ovf              = seg_co ^ seg_cm;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_q <= '0;
            end else if (in_ready) begin
                stg_q <= stg_d;
            end
        end
    end

    assign last_q    = g_stage[STAGES-1].stg_q;
    assign out_valid = last_q.valid;
    assign sum       = last_q.s[WIDTH-1:0];
    assign carry     = last_q.carry;
    assign ovf       = last_q.ovf;

endmodule

// File: doc/pipe_rca.md
PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter SEG, default 8: bits added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a, b  input  WIDTH each  operands, unsigned or two's complement.
REQ-008 cin  input  1  carry-in (borrow-in in subtract mode).
REQ-009 sub  input  1  1 = subtract; present only with PIPE_RCA_SUB_EN.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 sum  output  WIDTH  result.
REQ-013 carry  output  1  carry-out of the MSB.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 WIDTH shall be an integer multiple of SEG; otherwise elaboration shall fail.
REQ-016 Stage k shall add bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses cin.
REQ-017 Operand segments not yet added shall travel skewed with the beat; completed sum segments shall travel de-skewed, so all WIDTH sum bits emerge together.
REQ-018 Each stage shall hold a valid bit; a beat accepted in cycle N shall raise out_valid in cycle N+STAGES when no stall occurs.
REQ-019 A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
REQ-020 Stall: when out_valid && !out_ready, all stages shall hold, and in_ready shall be 0.
REQ-021 in_ready = !(out_valid && !out_ready); empty bubbles shall advance even while upstream is idle.
REQ-022 sum, carry, ovf shall stay stable while out_valid && !out_ready.
REQ-023 Throughput: one beat per cycle when out_ready is held at 1.
REQ-024 Results shall leave in acceptance order; no beat is dropped or duplicated.
REQ-025 Arithmetic shall be modulo 2^WIDTH; carry is bit WIDTH of the full sum.

Reset
REQ-026 While rst_n is 0, every stage valid bit, out_valid, sum, carry and ovf shall be 0, and in_ready shall be 1.
REQ-027 Reset mid-stream shall discard all in-flight beats; the first accepted beat after release shall produce the first out_valid.

Configuration
REQ-028 Macro PIPE_RCA_SUB_EN defined: sub port exists; sub=1 computes a + ~b + ~cin, i.e. a - b - cin; carry=1 means no borrow; sub travels with its beat.
REQ-029 PIPE_RCA_SUB_EN undefined: no sub port; the block is add-only, a + b + cin.

Structure
REQ-030 Package pipe_rca_pkg shall hold default WIDTH and SEG constants and a stage-record typedef: valid, carry, pending a/b, partial sum, and sub when enabled.
REQ-031 One sub-module, pipe_rca_seg, shall implement the combinational SEG-bit ripple segment, with carry-in and carry-out, plus carry into its MSB for ovf.

Verification (WIDTH=32, SEG=8, latency 4)
REQ-032 a=0xFFFFFFFF, b=1, cin=0 accepted at cycle N -> out_valid at N+4, sum=0, carry=1, ovf=0.
REQ-033 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, carry=0, ovf=1.
REQ-034 Ten back-to-back beats, a and b random in 0..100, cin random, with out_ready=1 -> ten consecutive results in order, each equal to a+b+cin. Stimulus is logged to input.txt and results to output.txt.
REQ-035 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0 and sum stable for those 3 cycles; no beat lost once out_ready returns to 1.
REQ-036 With PIPE_RCA_SUB_EN, sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, carry=0, ovf=0.
REQ-037 rst_n driven low with 3 beats in flight -> out_valid=0 immediately; no stale result appears after rst_n returns to 1.
